// File: rtl/btb_pkg.sv
// Shared types and width helpers for the set-associative branch target buffer.
package btb_pkg;

    localparam int unsigned BYTE_BITS = 8;

    // Flush sweep controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } btb_state_e;

    // Byte-offset bits below the index (instruction alignment).
    function automatic int unsigned inst_ofs_w(input int unsigned inst);
        return $clog2(inst / BYTE_BITS);
    endfunction

    // Set index width.
    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Tag width: everything above index and byte offset.
    function automatic int unsigned tag_w(input int unsigned addr,
                                          input int unsigned sets,
                                          input int unsigned inst);
        return addr - idx_w(sets) - inst_ofs_w(inst);
    endfunction

    // Way-number width; a single-way table still carries a 1-bit pointer.
    function automatic int unsigned way_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Picks the way to overwrite on allocation: lowest invalid way, else round-robin.
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned WW   = way_w(WAYS)
) (
    input  logic [WAYS-1:0] valid,
    input  logic [WW-1:0]   rr_ptr,
    output logic [WAYS-1:0] victim_oh,
    output logic [WW-1:0]   victim_bin,
    output logic            use_rr
);

    // Scan from the top way down so the lowest invalid way wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that leaves one unassigned would infer a latch.
        use_rr     = 1'b1;
        victim_bin = rr_ptr;
        victim_oh  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                use_rr     = 1'b0;
                victim_bin = WW'(w);
            end
        end
        victim_oh[victim_bin] = 1'b1;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered lookup, commit-time training,
// per-set round-robin replacement and a set-walking flush sweep.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned ADDR     = 32,
    parameter int unsigned INST     = 32,
    parameter int unsigned SETS     = 64,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned CNT      = 2,
    parameter int unsigned CNT_INIT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ADDR-1:0] pc,
    output logic            btb_hit,
    output logic [ADDR-1:0] btb_addr,
    output logic            btb_busy,
    input  logic            br_commit_,
    input  logic            br_taken_,
    input  logic            br_miss_,
    input  logic            jump_commit_,
    input  logic            jump_miss_,
    input  logic [ADDR-1:0] com_addr,
    input  logic [ADDR-1:0] com_tar_addr,
    input  logic            flush
);

    localparam int unsigned OFS = inst_ofs_w(INST);
    localparam int unsigned IDX = idx_w(SETS);
    localparam int unsigned TAG = tag_w(ADDR, SETS, INST);
    localparam int unsigned WW  = way_w(WAYS);

    localparam logic [CNT-1:0] CNT_MAX   = '1;
    localparam logic [CNT-1:0] CNT_ALLOC = CNT'(CNT_INIT);
    localparam logic [IDX-1:0] SET_LAST  = IDX'(SETS - 1);

    typedef struct packed {
        logic            valid;
        logic [TAG-1:0]  tag;
        logic [CNT-1:0]  cnt;
        logic [ADDR-1:0] target;
    } btb_entry_t;

    btb_entry_t     table_q [SETS][WAYS];
    logic [WW-1:0]  rr_q    [SETS];

    btb_state_e     state_q;
    logic [IDX-1:0] set_q;

    // Address split for lookup and training.
    logic [IDX-1:0] rd_idx, wr_idx;
    logic [TAG-1:0] rd_tag, wr_tag;
    logic           unused_ofs_bits;

    assign rd_idx = pc[IDX+OFS-1:OFS];
    assign rd_tag = pc[ADDR-1:IDX+OFS];
    assign wr_idx = com_addr[IDX+OFS-1:OFS];
    assign wr_tag = com_addr[ADDR-1:IDX+OFS];
    assign unused_ofs_bits = ^{pc[OFS-1:0], com_addr[OFS-1:0]};

    // Lookup: a way predicts taken only when valid, tag-equal and counter non-zero.
    logic            look_hit;
    logic [ADDR-1:0] look_addr;

    always_comb begin
        look_hit  = 1'b0;
        look_addr = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (table_q[rd_idx][w].valid && (table_q[rd_idx][w].tag == rd_tag) &&
                (table_q[rd_idx][w].cnt != '0)) begin
                look_hit  = 1'b1;
                look_addr = table_q[rd_idx][w].target;
            end
        end
    end

    // Tracking check for the committed PC: tag hit regardless of counter.
    logic            trk_hit;
    logic [WW-1:0]   trk_way;
    logic [WAYS-1:0] valid_vec;

    always_comb begin
        trk_hit   = 1'b0;
        trk_way   = '0;
        valid_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_vec[w] = table_q[wr_idx][w].valid;
            if (table_q[wr_idx][w].valid && (table_q[wr_idx][w].tag == wr_tag)) begin
                trk_hit = 1'b1;
                trk_way = WW'(w);
            end
        end
    end

    logic [WAYS-1:0] victim_oh;
    logic [WW-1:0]   victim_bin;
    logic            use_rr;
    logic [WW-1:0]   rr_next;

    btb_victim_sel #(
        .WAYS (WAYS),
        .WW   (WW)
    ) u_victim_sel (
        .valid      (valid_vec),
        .rr_ptr     (rr_q[wr_idx]),
        .victim_oh  (victim_oh),
        .victim_bin (victim_bin),
        .use_rr     (use_rr)
    );

    // When the round-robin pointer was used, victim_bin equals it.
    assign rr_next = (WAYS == 1) ? '0 : victim_bin + 1'b1;

    // Training decisions; branch commit takes priority over jump commit.
    logic           commit_ok, do_br, do_jmp;
    logic           upd_en, upd_tgt, alloc_en;
    logic [CNT-1:0] cur_cnt, upd_cnt, alloc_cnt;

    assign commit_ok = !reset && (state_q == IDLE) && !flush;
    assign do_br     = commit_ok && !br_commit_;
    assign do_jmp    = commit_ok && br_commit_ && !jump_commit_;
    assign cur_cnt   = table_q[wr_idx][trk_way].cnt;

    always_comb begin
        upd_en    = 1'b0;
        upd_tgt   = 1'b0;
        upd_cnt   = cur_cnt;
        alloc_en  = 1'b0;
        alloc_cnt = CNT_MAX;
        if (do_br) begin
            if (trk_hit) begin
                upd_en = 1'b1;
                if (!br_taken_) begin
                    if (br_miss_) upd_cnt = CNT_MAX;
                    else if (cur_cnt != CNT_MAX) upd_cnt = cur_cnt + 1'b1;
                end else if (cur_cnt != '0) begin
                    upd_cnt = cur_cnt - 1'b1;
                end
            end else if (!br_taken_) begin
                alloc_en  = 1'b1;
                alloc_cnt = CNT_ALLOC;
            end
        end else if (do_jmp) begin
            if (trk_hit) begin
                upd_en  = 1'b1;
                upd_cnt = CNT_MAX;
                upd_tgt = !jump_miss_;
            end else begin
                alloc_en = 1'b1;
            end
        end
    end

    // Table storage: flush sweep clears one set per cycle, otherwise apply training.
    // NOTE: the entry arrays carry no reset; only valid bits and rr pointers are cleared, by the sweep.
    always_ff @(posedge clk) begin
        if (state_q == FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                table_q[set_q][w].valid <= 1'b0;
            end
            rr_q[set_q] <= '0;
        end else begin
            if (upd_en) begin
                table_q[wr_idx][trk_way].cnt <= upd_cnt;
                if (upd_tgt) table_q[wr_idx][trk_way].target <= com_tar_addr;
            end
            if (alloc_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (victim_oh[w]) begin
                        table_q[wr_idx][w] <= '{valid: 1'b1, tag: wr_tag,
                                                cnt: alloc_cnt, target: com_tar_addr};
                    end
                end
                if (use_rr) rr_q[wr_idx] <= rr_next;
            end
        end
    end

    // Flush FSM plus registered lookup outputs, held at zero whenever the table is or becomes busy.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every read in this block sees pre-edge values.
        if (reset) begin
            state_q  <= FLUSH;
            set_q    <= '0;
            btb_busy <= 1'b1;
            btb_hit  <= 1'b0;
            btb_addr <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q  <= FLUSH;
                        set_q    <= '0;
                        btb_busy <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush) begin
                        set_q <= '0;
                    end else if (set_q == SET_LAST) begin
                        state_q  <= IDLE;
                        btb_busy <= 1'b0;
                    end else begin
                        set_q <= set_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= FLUSH;
                    set_q   <= '0;
                end
            endcase
            btb_hit  <= (state_q == IDLE) && !flush && look_hit;
            btb_addr <= ((state_q == IDLE) && !flush && look_hit) ? look_addr : '0;
        end
    end

endmodule
